dmem_arbiter: RTL

//  Shares one memory bus between the instruction-fetch port (I) and the memory-stage data port (D).

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares one memory bus between the fetch (I) and data (D) request ports, round-robin on collisions,
// with an optional watchdog that aborts transactions the slave never acknowledges.
module dmem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_i_req,
  input  logic [XLEN-1:0] i_i_addr,
  output logic            o_i_ack,
  output logic            o_i_err,
  output logic [XLEN-1:0] o_i_rd_data,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wr_data,
  input  logic [2:0]      i_d_f3,
  output logic            o_d_ack,
  output logic            o_d_err,
  output logic [XLEN-1:0] o_d_rd_data,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wr_data,
  output logic [2:0]      o_mem_f3,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rd_data,
  output logic            o_busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam bit             WD_EN   = (TIMEOUT > 0);
  localparam int             WDW     = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WD_EN ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [WDW-1:0] WD_MAX  = WD_EN ? WDW'(TIMEOUT) : '0;

  logic [1:0]      state;
  logic            last_grant_d;
  logic            we_r;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] wr_data_r;
  logic [2:0]      f3_r;
  logic [WDW-1:0]  wd;

  logic busy, busy_i, busy_d, timeout, done, grant_i, grant_d;

  assign busy    = (state != S_IDLE);
  assign busy_i  = (state == S_BUSY_I);
  assign busy_d  = (state == S_BUSY_D);
  // A real ack in the final watchdog cycle takes precedence over the abort.
  assign timeout = WD_EN && busy && !i_mem_ack && (wd == WD_LAST);
  assign done    = busy && (i_mem_ack || timeout);

  // On a collision the port that did not win last time is served.
  assign grant_d = !busy && i_d_req && (!i_i_req || !last_grant_d);
  assign grant_i = !busy && i_i_req && !grant_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      last_grant_d <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wr_data_r    <= '0;
      f3_r         <= 3'b000;
      wd           <= '0;
    end else if (!busy) begin
      wd <= '0;
      if (grant_d) begin
        state        <= S_BUSY_D;
        last_grant_d <= 1'b1;
        we_r         <= i_d_we;
        addr_r       <= i_d_addr;
        wr_data_r    <= i_d_wr_data;
        f3_r         <= i_d_f3;
      end else if (grant_i) begin
        state        <= S_BUSY_I;
        last_grant_d <= 1'b0;
        we_r         <= 1'b0;
        addr_r       <= i_i_addr;
        wr_data_r    <= '0;
        f3_r         <= 3'b010;
      end
    end else if (done) begin
      state <= S_IDLE;
      wd    <= '0;
    end else if (wd != WD_MAX) begin
      wd <= wd + 1'b1;
    end
  end

  assign o_mem_req     = busy;
  assign o_mem_we      = busy && we_r;
  assign o_mem_addr    = busy ? addr_r : '0;
  assign o_mem_wr_data = busy ? wr_data_r : '0;
  assign o_mem_f3      = busy ? f3_r : 3'b000;
  assign o_busy        = busy;

  assign o_i_ack     = busy_i && done;
  assign o_d_ack     = busy_d && done;
  assign o_i_err     = busy_i && timeout;
  assign o_d_err     = busy_d && timeout;
  assign o_i_rd_data = i_mem_rd_data;
  assign o_d_rd_data = i_mem_rd_data;
endmodule
